// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: address/data types, the register addresses
// reused by the address decoder, and the sprite-DMA state encoding.
package nes_bus_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  // CPU write here with page P starts a sprite DMA from P*256
  localparam addr_t NES_DMA_REG_ADDR  = 16'h4014;
  // PPU OAM data port; destination of every DMA write
  localparam addr_t NES_OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite (OAM) DMA controller.
// A CPU write to DMA_REG_ADDR with page P halts the CPU and copies
// XFER_LEN bytes from P*256.. into OAM via repeated writes to OAM_DATA_ADDR.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ce              CPU cycle enable (one CPU cycle = one clk edge with ce=1)
//   cpu_addr/we/wdata  CPU core bus request (trigger detection only)
//   bus_rdata       read data from decoder, valid at the ce edge ending a read
//   cpu_rdy         0 = CPU halted
//   dma_active      1 = bus mux selects dma_* signals
//   dma_addr/we/wdata  bus drive during DMA
// All outputs come straight from registers.
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter addr_t       DMA_REG_ADDR  = NES_DMA_REG_ADDR,
  parameter addr_t       OAM_DATA_ADDR = NES_OAM_DATA_ADDR,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_we,
  output logic [7:0]  dma_wdata
);

  localparam logic [7:0] LAST_COUNT = 8'(XFER_LEN - 1);

  dma_state_t r_state;
  logic [7:0]  r_page;
  logic [7:0]  r_count;
  logic [7:0]  r_data;
  logic        r_parity;
  logic        r_cpu_rdy;
  logic        r_active;
  logic        r_we;
  logic [15:0] r_addr;

  logic [7:0]  w_count_next;

  // Page is never incremented: the low byte alone wraps within the page.
  assign w_count_next = r_count + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_page    <= '0;
      r_count   <= '0;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_cpu_rdy <= 1'b1;
      r_active  <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
    end else if (ce) begin
      r_parity <= ~r_parity;
      unique case (r_state)
        IDLE: begin
          if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
            r_page    <= cpu_wdata;
            r_count   <= '0;
            r_state   <= HALT;
            r_cpu_rdy <= 1'b0;
            r_active  <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= {cpu_wdata, 8'h00};
          end
        end
        HALT: begin
          // r_parity is this cycle's parity; odd now means the next cycle
          // is even and may carry the first read directly.
          r_state <= r_parity ? READ : ALIGN;
        end
        ALIGN: begin
          r_state <= READ;
        end
        READ: begin
          r_data  <= bus_rdata;
          r_state <= WRITE;
          r_we    <= 1'b1;
          r_addr  <= OAM_DATA_ADDR;
        end
        WRITE: begin
          r_count <= w_count_next;
          r_we    <= 1'b0;
          if (r_count == LAST_COUNT) begin
            r_state   <= IDLE;
            r_cpu_rdy <= 1'b1;
            r_active  <= 1'b0;
            r_addr    <= '0;
          end else begin
            r_state <= READ;
            r_addr  <= {r_page, w_count_next};
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cpu_rdy <= 1'b1;
          r_active  <= 1'b0;
          r_we      <= 1'b0;
          r_addr    <= '0;
        end
      endcase
    end
  end

  assign cpu_rdy    = r_cpu_rdy;
  assign dma_active = r_active;
  assign dma_addr   = r_addr;
  assign dma_we     = r_we;
  assign dma_wdata  = r_data;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  bus_rdata;
  logic        cpu_rdy, dma_active, dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;

  int checks = 0;
  int passed = 0;

  oam_dma_ctrl dut (
    .clk(clk), .rst(rst), .ce(ce),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .bus_rdata(bus_rdata),
    .cpu_rdy(cpu_rdy), .dma_active(dma_active),
    .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata)
  );

  // RAM model contents: byte at address a
  function automatic logic [7:0] exp_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA7;  // page $02 gives i ^ $A5
  endfunction

  assign bus_rdata = exp_byte(dma_addr);

  always #5 if (clk_en) clk = ~clk;

  // ce generator: one ce clock out of every ce_div clocks
  int ce_div = 1;
  int div_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (div_cnt + 1 >= ce_div) begin div_cnt = 0; ce = 1'b1; end
    else begin div_cnt = div_cnt + 1; ce = 1'b0; end
  end

  // reference parity of the current CPU cycle
  logic tb_par;
  always @(posedge clk or posedge rst)
    if (rst) tb_par <= 1'b0;
    else if (ce) tb_par <= ~tb_par;

  typedef struct packed {
    logic        rdy, act, we, par;
    logic [15:0] addr;
    logic [7:0]  wd;
  } ent_t;
  ent_t log_q[$];
  logic log_en = 1'b0;

  logic        edge_ce = 1'b1;
  logic        hold_en = 1'b0;
  int          hold_err = 0;
  logic [26:0] snap = '0;

  always @(posedge clk) edge_ce = ce;

  always @(negedge clk) begin
    if (!rst) begin
      if (hold_en && !edge_ce &&
          ({cpu_rdy, dma_active, dma_we, dma_addr, dma_wdata} !== snap))
        hold_err++;
      snap = {cpu_rdy, dma_active, dma_we, dma_addr, dma_wdata};
      if (log_en && ce)
        log_q.push_back('{cpu_rdy, dma_active, dma_we, tb_par, dma_addr, dma_wdata});
    end
  end

  task automatic wait_ce();
    @(posedge clk iff ce);
    #2;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic we, input logic [7:0] d);
    cpu_addr = a; cpu_we = we; cpu_wdata = d;
    wait_ce();
    cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
  endtask

  // Trigger a DMA on a cycle of parity trig_par and log until cpu_rdy returns.
  // inject_at >= 0 issues another $4014 write that many cycles into the stall.
  task automatic run_transfer(input logic [7:0] page, input logic trig_par,
                              input int inject_at, output logic ok);
    log_q.delete();
    log_en = 1'b1;
    if (tb_par !== trig_par) wait_ce();
    cpu_write(16'h4014, 1'b1, page);
    for (int n = 0; n < 3000 && !cpu_rdy; n++) begin
      if (n == inject_at) begin
        cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_wdata = 8'h07;
      end
      wait_ce();
      cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
    end
    ok = cpu_rdy;
    wait_ce();
    wait_ce();
    log_en = 1'b0;
  endtask

  task automatic analyze(input logic [7:0] page, output int stall, n_pre, n_rd, n_wr,
                         bad_addr, bad_data, bad_par, bad_cons, output logic [15:0] last_rd);
    stall = 0; n_pre = 0; n_rd = 0; n_wr = 0;
    bad_addr = 0; bad_data = 0; bad_par = 0; bad_cons = 0; last_rd = '0;
    for (int i = 0; i < log_q.size(); i++) begin
      ent_t e;
      e = log_q[i];
      if (!e.rdy) stall++;
      if (e.rdy !== !e.act) bad_cons++;
      if (e.act && !e.we) begin
        if (i + 1 < log_q.size() && log_q[i+1].act && log_q[i+1].we) begin
          if (e.addr !== {page, 8'(n_rd)}) bad_addr++;
          if (e.par !== 1'b0) bad_par++;
          last_rd = e.addr;
          n_rd++;
        end else begin
          if (n_rd != 0) bad_cons++;
          if (e.addr !== {page, 8'h00}) bad_addr++;
          n_pre++;
        end
      end else if (e.act && e.we) begin
        if (e.addr !== 16'h2004) bad_addr++;
        if (e.wd !== exp_byte({page, 8'(n_wr)})) bad_data++;
        n_wr++;
      end
    end
  endtask

  int st, np, nr, nw, ba, bd, bp, bc;
  logic [15:0] lr;
  logic ok;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_rdy !== 1'b1) $display("FAIL reset_rdy got %b want 1", cpu_rdy); else passed++;
    checks++; if (dma_active !== 1'b0) $display("FAIL reset_active got %b want 0", dma_active); else passed++;
    checks++; if (dma_addr !== 16'h0000) $display("FAIL reset_addr got %h want 0000", dma_addr); else passed++;
    checks++; if (dma_we !== 1'b0) $display("FAIL reset_we got %b want 0", dma_we); else passed++;
    checks++; if (dma_wdata !== 8'h00) $display("FAIL reset_wdata got %h want 00", dma_wdata); else passed++;
    @(negedge clk);
    rst = 1'b0;
    wait_ce();
    wait_ce();
    checks++; if (cpu_rdy !== 1'b1 || dma_active !== 1'b0)
      $display("FAIL post_reset_idle got rdy=%b act=%b want 1/0", cpu_rdy, dma_active); else passed++;
  endtask

  task automatic test_even_trigger();
    run_transfer(8'h02, 1'b0, -1, ok);
    analyze(8'h02, st, np, nr, nw, ba, bd, bp, bc, lr);
    checks++; if (ok !== 1'b1) $display("FAIL even_timeout got %b want 1", ok); else passed++;
    checks++; if (st != 513) $display("FAIL even_stall got %0d want 513", st); else passed++;
    checks++; if (np != 1) $display("FAIL even_prefix got %0d want 1", np); else passed++;
    checks++; if (nr != 256 || nw != 256) $display("FAIL even_counts got %0d/%0d want 256/256", nr, nw); else passed++;
    checks++; if (ba != 0) $display("FAIL even_addr got %0d errors want 0", ba); else passed++;
    checks++; if (bd != 0) $display("FAIL even_data got %0d errors want 0", bd); else passed++;
    checks++; if (bp != 0) $display("FAIL even_read_parity got %0d odd reads want 0", bp); else passed++;
    checks++; if (bc != 0) $display("FAIL even_rdy_active got %0d errors want 0", bc); else passed++;
    checks++; if (lr !== 16'h02FF) $display("FAIL even_last_read got %h want 02FF", lr); else passed++;
  endtask

  task automatic test_odd_align();
    run_transfer(8'h02, 1'b1, -1, ok);
    analyze(8'h02, st, np, nr, nw, ba, bd, bp, bc, lr);
    checks++; if (ok !== 1'b1) $display("FAIL odd_timeout got %b want 1", ok); else passed++;
    checks++; if (st != 514) $display("FAIL odd_stall got %0d want 514", st); else passed++;
    checks++; if (np != 2) $display("FAIL odd_prefix got %0d want 2", np); else passed++;
    checks++; if (nr != 256 || nw != 256) $display("FAIL odd_counts got %0d/%0d want 256/256", nr, nw); else passed++;
    checks++; if (ba != 0 || bd != 0) $display("FAIL odd_addr_data got %0d/%0d errors want 0/0", ba, bd); else passed++;
    checks++; if (bp != 0) $display("FAIL odd_read_parity got %0d odd reads want 0", bp); else passed++;
    checks++; if (bc != 0) $display("FAIL odd_rdy_active got %0d errors want 0", bc); else passed++;
  endtask

  task automatic test_ce_throttle();
    ce_div = 12;
    repeat (30) @(posedge clk);
    wait_ce();
    hold_err = 0;
    hold_en = 1'b1;
    run_transfer(8'h02, 1'b0, -1, ok);
    hold_en = 1'b0;
    analyze(8'h02, st, np, nr, nw, ba, bd, bp, bc, lr);
    checks++; if (ok !== 1'b1) $display("FAIL thr_timeout got %b want 1", ok); else passed++;
    checks++; if (st != 513) $display("FAIL thr_stall got %0d want 513", st); else passed++;
    checks++; if (nr != 256 || nw != 256) $display("FAIL thr_counts got %0d/%0d want 256/256", nr, nw); else passed++;
    checks++; if (ba != 0 || bd != 0 || bp != 0) $display("FAIL thr_errors got a=%0d d=%0d p=%0d want 0", ba, bd, bp); else passed++;
    checks++; if (hold_err != 0) $display("FAIL thr_hold got %0d changes on ce=0 edges want 0", hold_err); else passed++;
    ce_div = 1;
    repeat (15) @(posedge clk);
    wait_ce();
  endtask

  task automatic test_reset_mid();
    int wcnt;
    wcnt = 0;
    cpu_write(16'h4014, 1'b1, 8'h05);
    for (int n = 0; n < 2000 && wcnt < 100; n++) begin
      wait_ce();
      if (dma_we) wcnt++;
    end
    wait_ce();
    checks++; if (wcnt != 100 || dma_active !== 1'b1)
      $display("FAIL mid_progress got writes=%0d act=%b want 100/1", wcnt, dma_active); else passed++;
    @(negedge clk);
    clk_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (cpu_rdy !== 1'b1) $display("FAIL mid_rst_rdy got %b want 1", cpu_rdy); else passed++;
    checks++; if (dma_active !== 1'b0 || dma_addr !== 16'h0000)
      $display("FAIL mid_rst_outputs got act=%b addr=%h want 0/0000", dma_active, dma_addr); else passed++;
    #1 rst = 1'b0;
    #1 clk_en = 1'b1;
    wait_ce();
    run_transfer(8'h03, 1'b0, -1, ok);
    analyze(8'h03, st, np, nr, nw, ba, bd, bp, bc, lr);
    checks++; if (ok !== 1'b1 || st != 513) $display("FAIL restart_stall got ok=%b stall=%0d want 1/513", ok, st); else passed++;
    checks++; if (nw != 256 || ba != 0 || bd != 0)
      $display("FAIL restart_xfer got writes=%0d aerr=%0d derr=%0d want 256/0/0", nw, ba, bd); else passed++;
  endtask

  task automatic test_page_ff();
    run_transfer(8'hFF, 1'b1, -1, ok);
    analyze(8'hFF, st, np, nr, nw, ba, bd, bp, bc, lr);
    checks++; if (ok !== 1'b1 || st != 514) $display("FAIL ff_stall got ok=%b stall=%0d want 1/514", ok, st); else passed++;
    checks++; if (lr !== 16'hFFFF) $display("FAIL ff_last_read got %h want FFFF", lr); else passed++;
    checks++; if (nr != 256 || ba != 0 || bd != 0)
      $display("FAIL ff_xfer got reads=%0d aerr=%0d derr=%0d want 256/0/0", nr, ba, bd); else passed++;
  endtask

  task automatic test_no_trigger();
    int bad;
    bad = 0;
    cpu_write(16'h4015, 1'b1, 8'h02);
    cpu_write(16'h4014, 1'b0, 8'h02);
    cpu_write(16'h4004, 1'b1, 8'h02);
    for (int n = 0; n < 4; n++) begin
      wait_ce();
      if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL no_trigger got %0d active cycles want 0", bad); else passed++;
  endtask

  task automatic test_retrigger_ignored();
    run_transfer(8'h02, 1'b0, 37, ok);
    analyze(8'h02, st, np, nr, nw, ba, bd, bp, bc, lr);
    checks++; if (ok !== 1'b1 || st != 513) $display("FAIL retrig_stall got ok=%b stall=%0d want 1/513", ok, st); else passed++;
    checks++; if (nw != 256 || ba != 0 || bd != 0)
      $display("FAIL retrig_xfer got writes=%0d aerr=%0d derr=%0d want 256/0/0", nw, ba, bd); else passed++;
  endtask

  task automatic test_back_to_back();
    // new trigger in the first IDLE cycle after completion
    run_transfer(8'h04, 1'b0, -1, ok);
    run_transfer(8'h06, tb_par, -1, ok);
    analyze(8'h06, st, np, nr, nw, ba, bd, bp, bc, lr);
    checks++; if (ok !== 1'b1 || nw != 256 || ba != 0 || bd != 0)
      $display("FAIL b2b_xfer got ok=%b writes=%0d aerr=%0d derr=%0d want 1/256/0/0", ok, nw, ba, bd); else passed++;
  endtask

  initial begin
    test_reset();
    test_even_trigger();
    test_odd_align();
    test_ce_throttle();
    test_reset_mid();
    test_page_ff();
    test_no_trigger();
    test_retrigger_ignored();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
